// File: rtl/wm_pkg.sv
// Shared constants for the washing-machine controller and its phase timer.
package wm_pkg;

    // Controller FSM state encodings
    localparam logic [2:0] CS_IDLE  = 3'd0;
    localparam logic [2:0] CS_FILL  = 3'd1;
    localparam logic [2:0] CS_WASH  = 3'd2;
    localparam logic [2:0] CS_RINSE = 3'd3;
    localparam logic [2:0] CS_SPIN  = 3'd4;
    localparam logic [2:0] CS_DONE  = 3'd5;

    // Timer FSM state encodings
    localparam logic [1:0] TS_IDLE = 2'd0;
    localparam logic [1:0] TS_RUN  = 2'd1;
    localparam logic [1:0] TS_HOLD = 2'd2;
    localparam logic [1:0] TS_DONE = 2'd3;

    // Wash mode selections
    localparam logic [1:0] MODE_NORMAL     = 2'd0;
    localparam logic [1:0] MODE_DELICATE   = 2'd1;
    localparam logic [1:0] MODE_HEAVY      = 2'd2;
    localparam logic [1:0] MODE_RINSE_ONLY = 2'd3;

    // Nominal phase durations, in timer decrements
    localparam int unsigned FILL_TIME  = 120;
    localparam int unsigned WASH_TIME  = 900;
    localparam int unsigned RINSE_TIME = 300;
    localparam int unsigned SPIN_TIME  = 240;

    // Default divider settings
    localparam int unsigned DEF_TICK_DIV   = 1;
    localparam int unsigned DEF_DIR_PERIOD = 1048576;
    localparam int unsigned DEF_SEC_DIV    = 1000000;

endpackage

// File: rtl/wm_tick_prescaler.sv
// Divide-by-N enable generator: advances on adv unless held, wraps at N-1,
// and flags the wrapping advance with a one-cycle tick.
module wm_tick_prescaler #(
    parameter int unsigned N = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic hold,
    input  logic adv,
    output logic tick
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt;
    logic          last;
    logic          step_en;

    assign last    = (cnt == CW'(N - 1));
    assign step_en = adv && !hold;
    assign tick    = step_en && last;

    // Count 0..N-1; clear wins over advancing, hold freezes the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (step_en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wash_phase_timer.sv
// Phase countdown timer for the washing-machine controller, with motor
// direction phase and a seconds tick derived from the decrement stream.
//
// Handshake: timer_start is a one-cycle load request sampled on the rising
// edge (no ready; it is always accepted unless abort is high on that edge);
// timer_done is a one-cycle pulse answering the load that expired.
module wash_phase_timer
    import wm_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned DIR_PERIOD = DEF_DIR_PERIOD,
    parameter int unsigned SEC_DIV    = DEF_SEC_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             timer_start,
    input  logic [WIDTH-1:0] timer_value,
    input  logic             pause,
    input  logic             abort,
    output logic             timer_done,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic             dir_phase,
    output logic             sec_tick,
    output logic [7:0]       elapsed_sec,
    output logic [1:0]       dbg_state
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       active;
    logic       div_clear;
    logic       pre_tick;
    logic       dec;
    logic       expire;
    logic       dir_tick;
    logic       sec_tick_c;

    assign dbg_state = state;
    assign active    = (state == TS_RUN) || (state == TS_HOLD);
    assign div_clear = abort || timer_start;
    // A decrement only happens on a count edge that is not overridden by
    // abort or a reload, and never from zero.
    assign dec       = pre_tick && !div_clear && (remaining != '0);
    assign expire    = dec && (remaining == WIDTH'(1));

    wm_tick_prescaler #(.N(TICK_DIV)) u_pre (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (div_clear),
        .hold    (pause),
        .adv     (active),
        .tick    (pre_tick)
    );

    wm_tick_prescaler #(.N(DIR_PERIOD)) u_dir (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (div_clear),
        .hold    (pause),
        .adv     (dec),
        .tick    (dir_tick)
    );

    wm_tick_prescaler #(.N(SEC_DIV)) u_sec (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (div_clear),
        .hold    (pause),
        .adv     (dec),
        .tick    (sec_tick_c)
    );

    // Next-state selection: abort, then reload, then expiry/pause tracking
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = TS_IDLE;
        end else if (timer_start) begin
            if (timer_value == '0) begin
                state_nxt = TS_DONE;
            end else begin
                state_nxt = pause ? TS_HOLD : TS_RUN;
            end
        end else if (active) begin
            if (expire) begin
                state_nxt = TS_DONE;
            end else begin
                state_nxt = pause ? TS_HOLD : TS_RUN;
            end
        end
    end

    // State, count and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= TS_IDLE;
            busy        <= 1'b0;
            timer_done  <= 1'b0;
            remaining   <= '0;
            dir_phase   <= 1'b0;
            sec_tick    <= 1'b0;
            elapsed_sec <= 8'd0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt == TS_RUN) || (state_nxt == TS_HOLD);
            timer_done <= 1'b0;
            sec_tick   <= 1'b0;
            if (abort) begin
                remaining <= '0;
            end else if (timer_start) begin
                remaining   <= timer_value;
                dir_phase   <= 1'b0;
                elapsed_sec <= 8'd0;
                timer_done  <= (timer_value == '0);
            end else if (dec) begin
                remaining  <= remaining - 1'b1;
                timer_done <= expire;
                if (dir_tick) begin
                    dir_phase <= ~dir_phase;
                end
                if (sec_tick_c) begin
                    sec_tick <= 1'b1;
                    if (elapsed_sec != 8'hFF) begin
                        elapsed_sec <= elapsed_sec + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer. Three instances share the stimulus:
// u_a (TICK_DIV=1, DIR_PERIOD=2, SEC_DIV=3), u_b (TICK_DIV=4), u_c (SEC_DIV=1).
module tb_wash_phase_timer;

    localparam int W = 16;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic         clk;
    logic         reset_n;
    logic         timer_start;
    logic [W-1:0] timer_value;
    logic         pause;
    logic         abort;

    logic         done_a, busy_a, dir_a, sec_a;
    logic [W-1:0] rem_a;
    logic [7:0]   el_a;
    logic [1:0]   st_a;
    logic         done_b, busy_b, dir_b, sec_b;
    logic [W-1:0] rem_b;
    logic [7:0]   el_b;
    logic [1:0]   st_b;
    logic         done_c, busy_c, dir_c, sec_c;
    logic [W-1:0] rem_c;
    logic [7:0]   el_c;
    logic [1:0]   st_c;

    int total = 0;
    int bad   = 0;

    wash_phase_timer #(.WIDTH(W), .TICK_DIV(1), .DIR_PERIOD(2), .SEC_DIV(3)) u_a (
        .clk(clk), .reset_n(reset_n), .timer_start(timer_start), .timer_value(timer_value),
        .pause(pause), .abort(abort), .timer_done(done_a), .busy(busy_a), .remaining(rem_a),
        .dir_phase(dir_a), .sec_tick(sec_a), .elapsed_sec(el_a), .dbg_state(st_a)
    );

    wash_phase_timer #(.WIDTH(W), .TICK_DIV(4), .DIR_PERIOD(2), .SEC_DIV(3)) u_b (
        .clk(clk), .reset_n(reset_n), .timer_start(timer_start), .timer_value(timer_value),
        .pause(pause), .abort(abort), .timer_done(done_b), .busy(busy_b), .remaining(rem_b),
        .dir_phase(dir_b), .sec_tick(sec_b), .elapsed_sec(el_b), .dbg_state(st_b)
    );

    wash_phase_timer #(.WIDTH(W), .TICK_DIV(1), .DIR_PERIOD(4), .SEC_DIV(1)) u_c (
        .clk(clk), .reset_n(reset_n), .timer_start(timer_start), .timer_value(timer_value),
        .pause(pause), .abort(abort), .timer_done(done_c), .busy(busy_c), .remaining(rem_c),
        .dir_phase(dir_c), .sec_tick(sec_c), .elapsed_sec(el_c), .dbg_state(st_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one-cycle load pulse; returns just after the load edge
    task automatic load(input logic [W-1:0] v);
        timer_start = 1'b1;
        timer_value = v;
        step();
        timer_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; timer_start = 1'b0; timer_value = '0; pause = 1'b0; abort = 1'b0;
        repeat (3) step();
        total++;
        if ({done_a, busy_a, dir_a, sec_a, rem_a, el_a, st_a} !== '0) begin
            $display("FAIL reset_outputs got rem=%0d done=%0d busy=%0d st=%0d exp all zero",
                     rem_a, done_a, busy_a, st_a);
            bad++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        total++;
        if (st_a !== S_IDLE || rem_a !== '0 || done_a !== 1'b0) begin
            $display("FAIL reset_release got st=%0d rem=%0d done=%0d exp st=0 rem=0 done=0",
                     st_a, rem_a, done_a);
            bad++;
        end
    endtask

    task automatic test_count5();
        load(16'd5);
        total++;
        if (rem_a !== 16'd5 || busy_a !== 1'b1 || done_a !== 1'b0) begin
            $display("FAIL count5_load got rem=%0d busy=%0d done=%0d exp rem=5 busy=1 done=0",
                     rem_a, busy_a, done_a);
            bad++;
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            total++;
            if (rem_a !== W'(5 - k) || done_a !== (k == 5) || busy_a !== (k != 5)) begin
                $display("FAIL count5_step%0d got rem=%0d done=%0d busy=%0d exp rem=%0d done=%0d busy=%0d",
                         k, rem_a, done_a, busy_a, 5 - k, (k == 5), (k != 5));
                bad++;
            end
        end
        step();
        total++;
        if (done_a !== 1'b0 || rem_a !== '0 || st_a !== S_DONE) begin
            $display("FAIL count5_after got done=%0d rem=%0d st=%0d exp done=0 rem=0 st=3",
                     done_a, rem_a, st_a);
            bad++;
        end
    endtask

    task automatic test_pause();
        int done_cyc;
        done_cyc = -1;
        load(16'd3);
        repeat (5) step();
        total++;
        if (rem_b !== 16'd2) begin
            $display("FAIL pause_prerun got rem=%0d exp 2", rem_b);
            bad++;
        end
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (rem_b !== 16'd2 || done_b !== 1'b0 || st_b !== S_HOLD) begin
                $display("FAIL pause_frozen%0d got rem=%0d done=%0d st=%0d exp rem=2 done=0 st=2",
                         k, rem_b, done_b, st_b);
                bad++;
            end
        end
        pause = 1'b0;
        for (int c = 16; c <= 40; c++) begin
            step();
            if (done_b === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        total++;
        if (done_cyc !== 22) begin
            $display("FAIL pause_done_cycle got %0d exp 22", done_cyc);
            bad++;
        end
    endtask

    task automatic test_zero();
        int busy_seen;
        busy_seen = 0;
        load(16'd0);
        total++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || st_a !== S_DONE) begin
            $display("FAIL zero_load got done=%0d busy=%0d st=%0d exp done=1 busy=0 st=3",
                     done_a, busy_a, st_a);
            bad++;
        end
        for (int k = 0; k < 4; k++) begin
            step();
            if (busy_a === 1'b1 || done_a === 1'b1) busy_seen++;
        end
        total++;
        if (busy_seen !== 0) begin
            $display("FAIL zero_after got busy_or_done_cycles=%0d exp 0", busy_seen);
            bad++;
        end
    endtask

    task automatic test_abort();
        int done_seen;
        done_seen = 0;
        load(16'd10);
        repeat (7) step();
        total++;
        if (rem_a !== 16'd3) begin
            $display("FAIL abort_pre got rem=%0d exp 3", rem_a);
            bad++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (st_a !== S_IDLE || rem_a !== '0 || done_a !== 1'b0 || busy_a !== 1'b0) begin
            $display("FAIL abort_state got st=%0d rem=%0d done=%0d busy=%0d exp 0 0 0 0",
                     st_a, rem_a, done_a, busy_a);
            bad++;
        end
        for (int k = 0; k < 6; k++) begin
            step();
            if (done_a === 1'b1) done_seen++;
        end
        total++;
        if (done_seen !== 0) begin
            $display("FAIL abort_nodone got done_pulses=%0d exp 0", done_seen);
            bad++;
        end
    endtask

    task automatic test_start_on_expiry();
        load(16'd2);
        step();
        timer_start = 1'b1;
        timer_value = 16'd4;
        step();
        timer_start = 1'b0;
        total++;
        if (rem_a !== 16'd4 || done_a !== 1'b0 || busy_a !== 1'b1) begin
            $display("FAIL expiry_reload got rem=%0d done=%0d busy=%0d exp rem=4 done=0 busy=1",
                     rem_a, done_a, busy_a);
            bad++;
        end
        repeat (4) step();
        total++;
        if (rem_a !== '0 || done_a !== 1'b1) begin
            $display("FAIL expiry_redone got rem=%0d done=%0d exp rem=0 done=1", rem_a, done_a);
            bad++;
        end
    endtask

    task automatic test_dir_sec();
        int toggles, ticks, done_cyc;
        logic prev_dir;
        toggles = 0; ticks = 0; done_cyc = -1;
        load(16'd12);
        prev_dir = dir_a;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (dir_a !== prev_dir) toggles++;
            prev_dir = dir_a;
            if (sec_a === 1'b1) ticks++;
            if (done_a === 1'b1) begin
                done_cyc = c;
                total++;
                if (el_a !== 8'd4) begin
                    $display("FAIL dirsec_elapsed got %0d exp 4", el_a);
                    bad++;
                end
            end
        end
        total++;
        if (toggles !== 6 || ticks !== 4 || done_cyc !== 12) begin
            $display("FAIL dirsec_counts got toggles=%0d ticks=%0d done_cyc=%0d exp 6 4 12",
                     toggles, ticks, done_cyc);
            bad++;
        end
    endtask

    task automatic test_saturate();
        int done_cyc;
        done_cyc = -1;
        load(16'd300);
        for (int c = 1; c <= 305; c++) begin
            step();
            if (c == 255 || c == 260) begin
                total++;
                if (el_c !== 8'd255) begin
                    $display("FAIL sat_elapsed_c%0d got %0d exp 255", c, el_c);
                    bad++;
                end
            end
            if (done_c === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        total++;
        if (done_cyc !== 300 || el_c !== 8'd255) begin
            $display("FAIL sat_done got cyc=%0d elapsed=%0d exp 300 255", done_cyc, el_c);
            bad++;
        end
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        done_seen = 0;
        load(16'd50);
        repeat (13) step();
        total++;
        if (rem_a !== 16'd37) begin
            $display("FAIL midrun_pre got rem=%0d exp 37", rem_a);
            bad++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({done_a, busy_a, dir_a, sec_a, rem_a, el_a, st_a} !== '0) begin
            $display("FAIL midrun_async got rem=%0d busy=%0d st=%0d exp all zero",
                     rem_a, busy_a, st_a);
            bad++;
        end
        repeat (2) step();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (done_a === 1'b1) done_seen++;
        end
        total++;
        if (done_seen !== 0 || st_a !== S_IDLE) begin
            $display("FAIL midrun_release got done_pulses=%0d st=%0d exp 0 0", done_seen, st_a);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_count5();
        test_pause();
        test_zero();
        test_abort();
        test_start_on_expiry();
        test_dir_sec();
        test_saturate();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wash_phase_timer.md
Name: wash_phase_timer

Overview:
- Countdown timer companion to the washing-machine controller FSM; consumes its timer_start/timer_value and returns timer_done.
- Also supplies the alternating motor-direction phase and a seconds tick for the display path.
- One instance per machine, clocked on the controller clock; freezes on pause and clears on abort.

Parameters:
WIDTH, 32, width of timer_value and remaining count
TICK_DIV, 1, clock cycles per count decrement (>=1); 1 = decrement every cycle
DIR_PERIOD, 1048576, decrements per motor-direction half-period (>=1)
SEC_DIV, 1000000, decrements per sec_tick pulse (>=1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
timer_start  in  1  load request, nominally a 1-cycle pulse
timer_value  in  WIDTH  count loaded on timer_start
pause  in  1  level; freezes all counting while high
abort  in  1  level/pulse; cancels current phase
timer_done  out  1  1-cycle pulse on expiry
busy  out  1  high in RUN or HOLD
remaining  out  WIDTH  current count
dir_phase  out  1  motor direction phase, toggles every DIR_PERIOD decrements
sec_tick  out  1  1-cycle pulse every SEC_DIV decrements
elapsed_sec  out  8  seconds since load, saturates at 255

Behaviour:
- Reset (async assert, sync release): state IDLE; remaining=0, timer_done=0, busy=0, dir_phase=0, sec_tick=0, elapsed_sec=0, prescaler and sub-counters=0.
- States: IDLE, RUN, HOLD, DONE. All outputs are registered.
- Priority per edge: abort > timer_start > expiry/count.
- abort (any state): go to IDLE; remaining=0; clear sub-counters; no timer_done.
- timer_start (any state, abort low): remaining=timer_value; prescaler, dir, sec counters and elapsed_sec cleared; dir_phase=0.
  - Next state is HOLD if pause=1, else RUN.
  - If timer_value==0: state DONE and timer_done=1 on the next cycle.
  - Start during RUN/HOLD restarts the phase. Start on the expiry edge reloads and suppresses that done pulse.
  - Start held high reloads every cycle, so the timer never expires; the FSM must pulse it.
- RUN: the prescaler counts 0..TICK_DIV-1; on wrap, remaining decrements by 1.
  - Decrement that yields 0: state DONE, timer_done=1 for exactly one cycle, busy=0 in the same cycle.
  - Latency with TICK_DIV=1 and no pause: start sampled at edge E0; remaining=V after E0; remaining=0 and timer_done=1 after edge E(V). Expiry is V cycles after the load edge, or V*TICK_DIV cycles in general.
- pause=1 in RUN: go to HOLD on the next edge; prescaler, remaining, dir and sec counters all frozen. pause=0 in HOLD: go to RUN and resume from the frozen prescaler value. No count is lost or added across a pause.
- pause in IDLE/DONE: ignored.
- dir_phase: a counter increments per decrement; at DIR_PERIOD it clears and dir_phase toggles. Frozen in HOLD; holds its value in DONE/IDLE.
- sec_tick/elapsed_sec: a counter increments per decrement; at SEC_DIV it clears, sec_tick pulses one cycle, and elapsed_sec increments, saturating at 255 with no wrap.
- DONE: remaining=0; stays until timer_start or abort. timer_done is never re-asserted without a new load.
- remaining never underflows; no decrement occurs at 0.

Decomposition:
- Shared package wm_pkg holds:
  - controller state encodings and timer state encodings
  - mode constants NORMAL/DELICATE/HEAVY/RINSE_ONLY
  - phase durations FILL_TIME, WASH_TIME, RINSE_TIME, SPIN_TIME
  - default TICK_DIV, DIR_PERIOD, SEC_DIV
- One sub-module wm_tick_prescaler: divide-by-N enable generator with clear and hold inputs, one-cycle tick output; reused for the dir and sec dividers.

Test Plan:
- Reset mid-RUN (remaining=37): assert reset_n=0 asynchronously -> all outputs 0 immediately, state IDLE; no timer_done after release.
- TICK_DIV=1, timer_value=5 pulse -> remaining 5,4,3,2,1,0 on successive cycles; timer_done high only in the cycle remaining=0; busy falls the same cycle.
- TICK_DIV=4, value=3, pause high for 10 cycles after 5 running cycles -> remaining frozen at 2 during pause; timer_done exactly 12+10=22 cycles after the load edge.
- timer_value=0 -> timer_done pulse the cycle after load, busy never high. Abort while remaining=3 -> IDLE, remaining=0, no done pulse. Start on the expiry edge -> no pulse, reload observed.
- DIR_PERIOD=2, SEC_DIV=3, value=12, TICK_DIV=1 -> dir_phase toggles every 2 cycles (6 toggles); sec_tick pulses 4 times; elapsed_sec=4 at done.
- SEC_DIV=1, value=300 -> elapsed_sec saturates at 255 and stays there; timer_done still fires at 300.
